cfg_write_sequencer: RTL and testbench

Arbitrates configuration writes from the PCIe host and a local scan engine, decodes them, and issues the single-cycle data/enable strobes that load the narrow-band width, filter mode and compare-start registers. After any filter-mode change, it enforces a guard interval so the filter pipeline can flush before the next write. It sits in the PCIE_dma_engine_clk domain, between the BAR-write decoder and the configuration register file.

---
 rtl/cfg_write_sequencer.sv | 139 +++++++++++++
 tb/tb_cfg_write_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_write_sequencer.sv
// Configuration write sequencer: arbitrates host/scan writes, issues register load strobes,
// and enforces a flush guard after filter-mode changes. Scan port gated by `CFG_SEQ_SCAN_PORT_EN.
module cfg_write_sequencer #(
   parameter int unsigned GUARD_CYCLES = 16
) (
   input  logic        PCIE_dma_engine_clk,
   input  logic        rst_n,
   input  logic        host_req,
   input  logic [3:0]  host_addr,
   input  logic [7:0]  host_wdata,
   output logic        host_ack,
   input  logic        scan_req,
   input  logic [3:0]  scan_addr,
   input  logic [7:0]  scan_wdata,
   output logic        scan_ack,
   output logic [7:0]  narrow_band_width,
   output logic        narrow_band_width_en,
   output logic [1:0]  filter_mode,
   output logic        filter_mode_en,
   output logic [7:0]  start_cmp_position,
   output logic        start_cmp_position_en,
   output logic        busy,
   output logic        addr_err,
   output logic [15:0] cfg_write_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] GUARD = 2'd2;

   logic [1:0] state;
   logic       last_scan;
   logic [1:0] shadow;
   logic       fm_change;
   logic [7:0] guard_cnt;
   logic       scan_valid;
   logic       grant_scan;
   logic [3:0] g_addr;
   logic [7:0] g_data;

`ifdef CFG_SEQ_SCAN_PORT_EN
   assign scan_valid = scan_req;
`else
   logic unused_scan_req;
   assign unused_scan_req = scan_req;
   assign scan_valid      = 1'b0;
`endif

   // Round-robin: on a tie the requester that was not granted last wins.
   always_comb begin
      grant_scan = 1'b0;
      if (scan_valid && (!host_req || !last_scan))
         grant_scan = 1'b1;
      g_addr = grant_scan ? scan_addr  : host_addr;
      g_data = grant_scan ? scan_wdata : host_wdata;
   end

   always_ff @(posedge PCIE_dma_engine_clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= IDLE;
         last_scan             <= 1'b1;
         shadow                <= 2'b00;
         fm_change             <= 1'b0;
         guard_cnt             <= '0;
         host_ack              <= 1'b0;
         scan_ack              <= 1'b0;
         narrow_band_width     <= 8'd25;
         narrow_band_width_en  <= 1'b0;
         filter_mode           <= 2'b00;
         filter_mode_en        <= 1'b0;
         start_cmp_position    <= '0;
         start_cmp_position_en <= 1'b0;
         busy                  <= 1'b0;
         addr_err              <= 1'b0;
         cfg_write_count       <= '0;
      end else begin
         host_ack              <= 1'b0;
         scan_ack              <= 1'b0;
         narrow_band_width_en  <= 1'b0;
         filter_mode_en        <= 1'b0;
         start_cmp_position_en <= 1'b0;
         addr_err              <= 1'b0;
         case (state)
            IDLE: begin
               if (host_req || scan_valid) begin
                  // The grant edge registers all ISSUE-cycle outputs so they appear one cycle later.
                  state     <= ISSUE;
                  busy      <= 1'b1;
                  last_scan <= grant_scan;
                  host_ack  <= !grant_scan;
                  scan_ack  <= grant_scan;
                  fm_change <= (g_addr == 4'h1) && (g_data[1:0] != shadow);
                  case (g_addr)
                     4'h0: begin
                        narrow_band_width    <= g_data;
                        narrow_band_width_en <= 1'b1;
                        cfg_write_count      <= cfg_write_count + 16'd1;
                     end
                     4'h1: begin
                        filter_mode     <= g_data[1:0];
                        filter_mode_en  <= 1'b1;
                        cfg_write_count <= cfg_write_count + 16'd1;
                     end
                     4'h2: begin
                        start_cmp_position    <= g_data;
                        start_cmp_position_en <= 1'b1;
                        cfg_write_count       <= cfg_write_count + 16'd1;
                     end
                     default: addr_err <= 1'b1;
                  endcase
               end
            end
            ISSUE: begin
               if (fm_change) begin
                  shadow    <= filter_mode;
                  guard_cnt <= 8'(GUARD_CYCLES - 1);
                  state     <= GUARD;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            GUARD: begin
               if (guard_cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  guard_cnt <= guard_cnt - 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_write_sequencer.sv
// Directed self-checking bench for cfg_write_sequencer (GUARD_CYCLES = 16).
module tb_cfg_write_sequencer;

   logic        clk;
   logic        rst_n;
   logic        host_req;
   logic [3:0]  host_addr;
   logic [7:0]  host_wdata;
   logic        host_ack;
   logic        scan_req;
   logic [3:0]  scan_addr;
   logic [7:0]  scan_wdata;
   logic        scan_ack;
   logic [7:0]  nbw;
   logic        nbw_en;
   logic [1:0]  fm;
   logic        fm_en;
   logic [7:0]  scp;
   logic        scp_en;
   logic        busy;
   logic        addr_err;
   logic [15:0] cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   logic seen;

   cfg_write_sequencer #(.GUARD_CYCLES(16)) dut (
      .PCIE_dma_engine_clk  (clk),
      .rst_n                (rst_n),
      .host_req             (host_req),
      .host_addr            (host_addr),
      .host_wdata           (host_wdata),
      .host_ack             (host_ack),
      .scan_req             (scan_req),
      .scan_addr            (scan_addr),
      .scan_wdata           (scan_wdata),
      .scan_ack             (scan_ack),
      .narrow_band_width    (nbw),
      .narrow_band_width_en (nbw_en),
      .filter_mode          (fm),
      .filter_mode_en       (fm_en),
      .start_cmp_position   (scp),
      .start_cmp_position_en(scp_en),
      .busy                 (busy),
      .addr_err             (addr_err),
      .cfg_write_count      (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits on negedges for the selected ack; returns the number of negedges taken.
   task automatic wait_ack(input bit sel_scan, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sel_scan ? scan_ack : host_ack) && n < 100);
      if (!(sel_scan ? scan_ack : host_ack))
         check(sel_scan ? "scan_ack_timeout" : "host_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic host_drive(input logic [3:0] a, input logic [7:0] d);
      host_addr  = a;
      host_wdata = d;
      host_req   = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      host_req = 1'b0; host_addr = '0; host_wdata = '0;
      scan_req = 1'b0; scan_addr = '0; scan_wdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_nbw", nbw, 32'd25);
      check("rst_fm", fm, 32'd0);
      check("rst_scp", scp, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_cnt", cnt, 32'd0);
      check("rst_strobes", {nbw_en, fm_en, scp_en, host_ack, scan_ack, addr_err}, 32'd0);

      // Host write 0x0 = 0x40: strobe one cycle after the grant sample
      host_drive(4'h0, 8'h40);
      wait_ack(1'b0, cyc);
      check("w0_latency", cyc, 32'd1);
      check("w0_nbw", nbw, 32'h40);
      check("w0_en", {nbw_en, fm_en, scp_en}, 32'b100);
      check("w0_cnt", cnt, 32'd1);
      check("w0_busy", busy, 32'd1);
      host_req = 1'b0;
      @(negedge clk);
      check("w0_pulse_end", {nbw_en, host_ack}, 32'd0);
      check("w0_hold", nbw, 32'h40);

      // Undefined address
      @(negedge clk);
      host_drive(4'h7, 8'hAA);
      wait_ack(1'b0, cyc);
      check("bad_err", addr_err, 32'd1);
      check("bad_no_en", {nbw_en, fm_en, scp_en}, 32'd0);
      check("bad_cnt", cnt, 32'd1);
      host_req = 1'b0;
      @(negedge clk);
      check("bad_err_pulse", addr_err, 32'd0);

      // Filter-mode change starts the guard; next write is held off
      @(negedge clk);
      host_drive(4'h1, 8'hFD);
      wait_ack(1'b0, cyc);
      check("fm_en", fm_en, 32'd1);
      check("fm_val", fm, 32'd1);
      check("fm_cnt", cnt, 32'd2);
      host_req = 1'b0;
`ifdef CFG_SEQ_SCAN_PORT_EN
      scan_addr = 4'h0; scan_wdata = 8'h55; scan_req = 1'b1;
      wait_ack(1'b1, cyc);
      scan_req = 1'b0;
`else
      @(negedge clk);
      host_drive(4'h0, 8'h55);
      wait_ack(1'b0, cyc);
      cyc = cyc + 1;
      host_req = 1'b0;
`endif
      check("guard_gap", cyc, 32'd18);
      check("guard_nbw", nbw, 32'h55);
      check("guard_fm_hold", fm, 32'd1);
      check("guard_cnt", cnt, 32'd3);

      // Same filter mode again: no guard
      @(negedge clk);
      host_drive(4'h1, 8'h01);
      wait_ack(1'b0, cyc);
      check("fm2_en", fm_en, 32'd1);
      check("fm2_cnt", cnt, 32'd4);
      host_req = 1'b0;
      @(negedge clk);
      check("fm2_no_guard", busy, 32'd0);

      // Reset while in GUARD with a pending request
      host_drive(4'h1, 8'h00);
      wait_ack(1'b0, cyc);
      host_req = 1'b0;
      repeat (3) @(negedge clk);
      check("guard_busy", busy, 32'd1);
      host_drive(4'h0, 8'h77);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 32'd0);
      check("abort_vals", {nbw, fm, scp}, {8'd25, 2'd0, 8'd0});
      check("abort_cnt", cnt, 32'd0);
      host_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | host_ack | scan_ack | nbw_en | fm_en | scp_en | busy;
      end
      check("abort_no_ack", seen, 32'd0);
      check("abort_nbw", nbw, 32'd25);

`ifdef CFG_SEQ_SCAN_PORT_EN
      // Tie after reset: host first, scan second
      host_drive(4'h2, 8'h10);
      scan_addr = 4'h2; scan_wdata = 8'h20; scan_req = 1'b1;
      @(negedge clk);
      check("tie_first", {host_ack, scan_ack}, 32'b10);
      check("tie_scp1", scp, 32'h10);
      check("tie_en1", scp_en, 32'd1);
      host_req = 1'b0;
      @(negedge clk);
      check("tie_gap", scp_en, 32'd0);
      @(negedge clk);
      check("tie_second", {host_ack, scan_ack}, 32'b01);
      check("tie_scp2", scp, 32'h20);
      check("tie_en2", scp_en, 32'd1);
      check("tie_cnt", cnt, 32'd2);
      scan_req = 1'b0;
      @(negedge clk);
`else
      // Scan port disabled: requests ignored
      scan_addr = 4'h0; scan_wdata = 8'h99; scan_req = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | scan_ack | busy | nbw_en;
      end
      check("scan_ignored", seen, 32'd0);
      check("scan_nbw", nbw, 32'd25);
      scan_req = 1'b0;
`endif

      // Count wrap
      @(negedge clk);
      force dut.cfg_write_count = 16'hFFFF;
      @(negedge clk);
      release dut.cfg_write_count;
      @(negedge clk);
      check("wrap_pre", cnt, 32'hFFFF);
      host_drive(4'h2, 8'h33);
      wait_ack(1'b0, cyc);
      check("wrap_cnt", cnt, 32'h0000);
      check("wrap_scp", scp, 32'h33);
      host_req = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
